// File: rtl/led_pulse_stretcher_if.sv
// rtl/led_pulse_stretcher_if.sv - event-in / blink-out signal bundle for the LED pulse stretcher
interface led_pulse_stretcher_if #(
    parameter int unsigned PEND_WIDTH = 3
);
    logic                  event_i;
    logic                  led_o;
    logic                  busy_o;
    logic [PEND_WIDTH-1:0] pend_o;
    logic                  overflow_o;

    modport master (
        output event_i,
        input  led_o,
        input  busy_o,
        input  pend_o,
        input  overflow_o
    );

    modport slave (
        input  event_i,
        output led_o,
        output busy_o,
        output pend_o,
        output overflow_o
    );
endinterface

// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - stretches single-cycle event pulses into queued, human-visible blinks
module led_pulse_stretcher #(
    parameter int unsigned ON_CYCLES    = 25_000_000,
    parameter int unsigned OFF_CYCLES   = 12_500_000,
    parameter int unsigned CNT_WIDTH    = 25,
    parameter int unsigned PEND_WIDTH   = 3,
    parameter logic        ACTIVE_STATE = 1'b1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    led_pulse_stretcher_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  OFF_LOAD = CNT_WIDTH'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

    state_t                state;
    state_t                state_n;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_n;
    logic [PEND_WIDTH-1:0] pend;
    logic [PEND_WIDTH-1:0] pend_n;
    logic                  ovf_n;
    logic                  consume;
    logic                  start_direct;
    logic                  led_q;
    logic                  busy_q;
    logic                  ovf_q;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pend_n       = pend;
        ovf_n        = 1'b0;
        consume      = 1'b0;
        start_direct = 1'b0;

        case (state)
            IDLE: begin
                if (bus.event_i) begin
                    state_n = ON;
                    cnt_n   = ON_LOAD;
                end
            end
            ON: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = OFF_LOAD;
                end else begin
                    cnt_n = cnt - CNT_WIDTH'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (pend != '0 || bus.event_i) begin
                        state_n      = ON;
                        cnt_n        = ON_LOAD;
                        consume      = (pend != '0);
                        start_direct = (pend == '0);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A consume in the same cycle makes room, so the event is never dropped then
        if (bus.event_i && state != IDLE) begin
            if (consume || start_direct) begin
                pend_n = pend;
            end else if (pend == PEND_MAX) begin
                ovf_n = 1'b1;
            end else begin
                pend_n = pend + PEND_WIDTH'(1);
            end
        end else if (consume) begin
            pend_n = pend - PEND_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pend   <= '0;
            led_q  <= ~ACTIVE_STATE;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend   <= pend_n;
            led_q  <= (state_n == ON) ? ACTIVE_STATE : ~ACTIVE_STATE;
            busy_q <= (state_n != IDLE);
            ovf_q  <= ovf_n;
        end
    end

    assign bus.led_o      = led_q;
    assign bus.busy_o     = busy_q;
    assign bus.pend_o     = pend;
    assign bus.overflow_o = ovf_q;
endmodule
